data_memory_ctrl: RTL and testbench
===================================

# data_memory_ctrl

Parametrised successor to the processor's data-memory wrapper. It decodes the top 16 address bits into NUM_BANKS on-chip RAM banks plus one external MMIO window. It supports byte, halfword and word loads and stores, with sign or zero extension and alignment checking. Requests use a valid/ready handshake; responses arrive as a one-cycle pulse, and MMIO accesses wait for an acknowledge with a timeout. It sits between the MIPS core's memory stage and the stack, static-data and serial devices.

## Interface
- NUM_BANKS, 2, number of RAM banks (1..4)
- BANK_TAGS, {16'h7fff,16'h1000}, packed 16-bit tags; bank i matches addr_in[31:16] == BANK_TAGS[16i+15:16i]
- BANK_AW, 10, word-address bits per bank (2^BANK_AW words; 10 = 4 KB)
- MMIO_TAG, 16'hffff, tag of external MMIO window
- MMIO_TIMEOUT, 255, cycles to wait for mmio_ack_in (1..65535)
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high
- req_valid_in  input  1  request present
- req_ready_out  output  1  block can accept a request
- addr_in  input  32  byte address
- we_in  input  1  1 = store, 0 = load
- size_in  input  2  00 byte, 01 half, 11 word, 10 illegal
- signed_in  input  1  sign-extend sub-word loads
- writedata_in  input  32  store data, right-justified
- rsp_valid_out  output  1  one-cycle response pulse
- readdata_out  output  32  load result, extended
- rsp_err_out  output  1  access faulted (qualified by rsp_valid_out)
- mmio_req_out  output  1  MMIO access pending
- mmio_we_out  output  1  MMIO store
- mmio_addr_out  output  32  MMIO byte address
- mmio_be_out  output  4  MMIO byte enables
- mmio_wdata_out  output  32  lane-replicated store data
- mmio_ack_in  input  1  MMIO access complete
- mmio_rdata_in  input  32  MMIO raw read word

## Operation
- FSM states: IDLE, MMIO_WAIT, RESP. req_ready_out = (state == IDLE). Handshake completes on any edge where req_valid_in && req_ready_out.
- Decode priority: MMIO_TAG first, then bank 0..NUM_BANKS-1, lowest index wins. No match means unmapped.
- Faults (unmapped, size 10, half with addr[0]=1, word with addr[1:0]!=0): no side effects; go to RESP with err=1 and readdata 0.
- Byte enables (little-endian): byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'hF.
- Write lanes: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
- Bank access: the write is applied on the accept edge using byte enables; the read is issued on the same edge. Then go to RESP.
- MMIO access: on accept, register addr/we/be/wdata, clear the timeout counter, go to MMIO_WAIT. mmio_req_out is high and all mmio_* outputs are stable throughout MMIO_WAIT.
  - On an edge with mmio_ack_in=1: capture mmio_rdata_in and go to RESP with err=0.
  - When the counter reaches MMIO_TIMEOUT without ack: go to RESP with err=1. If ack and timeout coincide, ack wins.
- RESP: rsp_valid_out=1 for exactly one cycle, then IDLE.
  - Load data is extracted from the lane selected by addr[1:0], then zero- or sign-extended per signed_in.
  - For stores, readdata_out=0.
- mmio_ack_in outside MMIO_WAIT is ignored. Responses have no backpressure.

## Timing
- Reset values: req_ready_out 1 (state IDLE), rsp_valid_out 0, readdata_out 0, rsp_err_out 0, all mmio_* outputs 0.
- Reset asserted mid-transaction: returns to IDLE immediately (asynchronous). A pending MMIO request drops and no response is issued. Bank contents are not cleared by reset.
- Bank access: accept at edge E, rsp_valid_out high in the cycle after E. Throughput is one request per 2 cycles.
- Fault: same latency as a bank access.
- MMIO: mmio_req_out rises the cycle after accept. If ack is sampled at edge A, rsp_valid_out is high in the cycle after A and mmio_req_out is low in that cycle.
- Timeout: mmio_req_out stays high for exactly MMIO_TIMEOUT cycles, then RESP.
- A store followed by a load of the same address returns the new data.

## Structure
- Package dmem_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings
  - FSM state encodings
  - byte-enable function
  - lane-replication function
  - load extract/extend function
- Sub-module dmem_bank, one per bank: four 2^BANK_AW x 8 byte lanes, per-lane write enable, synchronous registered read.
- Top level holds the decoder, FSM, MMIO registers and timeout counter. Response data is formatted from the registered address offset, size and signed_in.

## Test plan
- sw 0xDEADBEEF to 0x10000004, then lw 0x10000004: rsp one cycle after each accept, err 0, readdata 0xDEADBEEF.
- sb 0x80 to 0x7fff0003, then lb and lbu of the same address: 0xFFFFFF80 then 0x00000080. lw 0x7fff0000 shows only the top byte changed.
- lh at 0x10000001, lw at 0x10000002, size 10, lw at 0x20000000: each returns err=1 and readdata 0, and a follow-up lw shows memory unchanged.
- MMIO lw at 0xffff0008 with ack 3 cycles later and rdata 0x0000005A:
  - mmio_be_out 4'hF, addresses/data stable while waiting.
  - rsp the cycle after ack, readdata 0x5A.
- MMIO access with ack never given and MMIO_TIMEOUT=4: mmio_req_out high exactly 4 cycles, then rsp with err=1. Ack coinciding with the timeout cycle gives err=0.
- Reset asserted while in MMIO_WAIT: mmio_req_out and rsp_valid_out drop immediately, req_ready_out=1. A prior bank store still reads back after reset.

Source files
------------

// File: rtl/data_memory_ctrl_pkg.sv
// Shared encodings and lane helpers for the data-memory controller.
// Byte enables, store-lane replication and load extraction live here so the top stays small.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MMIO_WAIT = 2'd1,
    ST_RESP      = 2'd2
  } state_e;

  function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: be_f = 4'b0001 << off;
      SIZE_HALF: be_f = 4'b0011 << off;
      default:   be_f = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] lanes_f(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SIZE_BYTE: lanes_f = {4{wd[7:0]}};
      SIZE_HALF: lanes_f = {2{wd[15:0]}};
      default:   lanes_f = wd;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  function automatic logic [31:0] load_fmt_f(input logic [31:0] raw, input logic [1:0] size,
                                             input logic [1:0] off, input logic sgn);
    logic [31:0] sh;
    sh = raw >> {off, 3'b000};
    case (size)
      SIZE_BYTE: load_fmt_f = {{24{sgn & sh[7]}}, sh[7:0]};
      SIZE_HALF: load_fmt_f = {{16{sgn & sh[15]}}, sh[15:0]};
      default:   load_fmt_f = raw;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Core-side request/response handshake plus the external MMIO bus.
// The controller is the slave on the core side and drives the MMIO side.
interface data_memory_ctrl_if;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [31:0] addr_in;
  logic        we_in;
  logic [1:0]  size_in;
  logic        signed_in;
  logic [31:0] writedata_in;
  logic        rsp_valid_out;
  logic [31:0] readdata_out;
  logic        rsp_err_out;
  logic        mmio_req_out;
  logic        mmio_we_out;
  logic [31:0] mmio_addr_out;
  logic [3:0]  mmio_be_out;
  logic [31:0] mmio_wdata_out;
  logic        mmio_ack_in;
  logic [31:0] mmio_rdata_in;

  modport slave (
    input  req_valid_in, addr_in, we_in, size_in, signed_in, writedata_in,
           mmio_ack_in, mmio_rdata_in,
    output req_ready_out, rsp_valid_out, readdata_out, rsp_err_out,
           mmio_req_out, mmio_we_out, mmio_addr_out, mmio_be_out, mmio_wdata_out
  );

  modport master (
    output req_valid_in, addr_in, we_in, size_in, signed_in, writedata_in,
           mmio_ack_in, mmio_rdata_in,
    input  req_ready_out, rsp_valid_out, readdata_out, rsp_err_out,
           mmio_req_out, mmio_we_out, mmio_addr_out, mmio_be_out, mmio_wdata_out
  );
endinterface

// File: rtl/data_memory_ctrl_bank.sv
// One RAM bank: four byte-wide lanes with per-lane write enable and a registered read.
// Contents are intentionally never reset.
module dmem_bank #(
  parameter int AW = 10
) (
  input  logic          clock,
  input  logic          en_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] mem [2**AW];
    logic [7:0] rd_q;

    always_ff @(posedge clock) begin
      if (en_i) begin
        if (be_i[b]) mem[addr_i] <= wdata_i[8*b +: 8];
        rd_q <= mem[addr_i];
      end
    end

    assign rdata_o[8*b +: 8] = rd_q;
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data-memory controller: decodes banks and an MMIO window, checks alignment,
// and returns one response pulse per request; MMIO waits for ack with a timeout.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int                      NUM_BANKS    = 2,
  parameter logic [16*NUM_BANKS-1:0] BANK_TAGS    = {16'h7fff, 16'h1000},
  parameter int                      BANK_AW      = 10,
  parameter logic [15:0]             MMIO_TAG     = 16'hffff,
  parameter int                      MMIO_TIMEOUT = 255
) (
  input logic             clock,
  input logic             reset,
  data_memory_ctrl_if.slave bus
);

  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  state_e        state_q;
  logic [1:0]    off_q, size_q;
  logic          sgn_q, we_q, err_q, src_mmio_q;
  logic [BW-1:0] bank_sel_q;
  logic [15:0]   cnt_q;
  logic [31:0]   mmio_rdata_q, mmio_addr_q, mmio_wdata_q;
  logic [3:0]    mmio_be_q;
  logic          mmio_we_q;

  logic          accept, hit_mmio, bank_hit, fault, misalign;
  logic [BW-1:0] bank_idx;
  logic [3:0]    req_be;
  logic [31:0]   req_wd, raw;
  logic [NUM_BANKS-1:0]       bank_en;
  logic [NUM_BANKS-1:0][31:0] bank_rdata;

  assign accept = bus.req_valid_in && (state_q == ST_IDLE);
  assign req_be = be_f(bus.size_in, bus.addr_in[1:0]);
  assign req_wd = lanes_f(bus.size_in, bus.writedata_in);

  // Lowest-index bank wins, so scan downward and let later matches overwrite.
  always_comb begin
    hit_mmio = (bus.addr_in[31:16] == MMIO_TAG);
    bank_hit = 1'b0;
    bank_idx = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (bus.addr_in[31:16] == BANK_TAGS[16*i +: 16]) begin
        bank_hit = 1'b1;
        bank_idx = BW'(i);
      end
    end
  end

  assign misalign = (bus.size_in == 2'b10) ||
                    (bus.size_in == SIZE_HALF && bus.addr_in[0]) ||
                    (bus.size_in == SIZE_WORD && bus.addr_in[1:0] != 2'b00);
  assign fault    = misalign || (!hit_mmio && !bank_hit);

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    assign bank_en[i] = accept && !fault && !hit_mmio && (bank_idx == BW'(i));

    dmem_bank #(.AW(BANK_AW)) u_bank (
      .clock   (clock),
      .en_i    (bank_en[i]),
      .be_i    (bus.we_in ? req_be : 4'h0),
      .addr_i  (bus.addr_in[BANK_AW+1:2]),
      .wdata_i (req_wd),
      .rdata_o (bank_rdata[i])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      off_q        <= '0;
      size_q       <= '0;
      sgn_q        <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      src_mmio_q   <= 1'b0;
      bank_sel_q   <= '0;
      cnt_q        <= '0;
      mmio_rdata_q <= '0;
      mmio_addr_q  <= '0;
      mmio_wdata_q <= '0;
      mmio_be_q    <= '0;
      mmio_we_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.req_valid_in) begin
          off_q      <= bus.addr_in[1:0];
          size_q     <= bus.size_in;
          sgn_q      <= bus.signed_in;
          we_q       <= bus.we_in;
          bank_sel_q <= bank_idx;
          err_q      <= fault;
          src_mmio_q <= !fault && hit_mmio;
          if (!fault && hit_mmio) begin
            mmio_addr_q  <= bus.addr_in;
            mmio_we_q    <= bus.we_in;
            mmio_be_q    <= req_be;
            mmio_wdata_q <= req_wd;
            cnt_q        <= '0;
            state_q      <= ST_MMIO_WAIT;
          end else begin
            state_q <= ST_RESP;
          end
        end
        // Ack takes priority over an expiring timeout on the same edge.
        ST_MMIO_WAIT: begin
          if (bus.mmio_ack_in) begin
            mmio_rdata_q <= bus.mmio_rdata_in;
            state_q      <= ST_RESP;
          end else if (cnt_q == 16'(MMIO_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign raw = src_mmio_q ? mmio_rdata_q : bank_rdata[bank_sel_q];

  assign bus.req_ready_out  = (state_q == ST_IDLE);
  assign bus.rsp_valid_out  = (state_q == ST_RESP);
  assign bus.rsp_err_out    = (state_q == ST_RESP) && err_q;
  assign bus.readdata_out   = (state_q == ST_RESP && !err_q && !we_q) ?
                              load_fmt_f(raw, size_q, off_q, sgn_q) : 32'h0;
  assign bus.mmio_req_out   = (state_q == ST_MMIO_WAIT);
  assign bus.mmio_we_out    = mmio_we_q;
  assign bus.mmio_addr_out  = mmio_addr_q;
  assign bus.mmio_be_out    = mmio_be_q;
  assign bus.mmio_wdata_out = mmio_wdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: bank loads/stores, faults, MMIO ack/timeout, async reset.
module tb_data_memory_ctrl;
  import dmem_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  data_memory_ctrl_if bus();

  data_memory_ctrl #(
    .NUM_BANKS    (2),
    .BANK_TAGS    ({16'h7fff, 16'h1000}),
    .BANK_AW      (10),
    .MMIO_TAG     (16'hffff),
    .MMIO_TIMEOUT (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic xact(input logic [31:0] a, input logic w, input logic [1:0] sz,
                      input logic sg, input logic [31:0] wd,
                      output logic v, output logic e, output logic [31:0] rd);
    @(negedge clock);
    bus.req_valid_in = 1'b1; bus.addr_in = a; bus.we_in = w;
    bus.size_in = sz; bus.signed_in = sg; bus.writedata_in = wd;
    @(posedge clock);
    #1 bus.req_valid_in = 1'b0;
    @(negedge clock);
    v = bus.rsp_valid_out; e = bus.rsp_err_out; rd = bus.readdata_out;
  endtask

  task automatic mmio_start(input logic [31:0] a, input logic w, input logic [1:0] sz,
                            input logic [31:0] wd);
    @(negedge clock);
    bus.req_valid_in = 1'b1; bus.addr_in = a; bus.we_in = w;
    bus.size_in = sz; bus.signed_in = 1'b0; bus.writedata_in = wd;
    @(posedge clock);
    #1 bus.req_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (bus.req_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", bus.req_ready_out); end
    total++; if (bus.rsp_valid_out !== 1'b0) begin bad++; $display("FAIL reset_rsp got %b want 0", bus.rsp_valid_out); end
    total++; if (bus.readdata_out !== 32'h0) begin bad++; $display("FAIL reset_rd got %h want 0", bus.readdata_out); end
    total++; if (bus.rsp_err_out !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", bus.rsp_err_out); end
    total++; if ({bus.mmio_req_out, bus.mmio_we_out, bus.mmio_be_out} !== 6'h0) begin bad++; $display("FAIL reset_mmio_ctl got %b want 0", {bus.mmio_req_out, bus.mmio_we_out, bus.mmio_be_out}); end
    total++; if ({bus.mmio_addr_out, bus.mmio_wdata_out} !== 64'h0) begin bad++; $display("FAIL reset_mmio_bus got %h want 0", {bus.mmio_addr_out, bus.mmio_wdata_out}); end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_word();
    logic v, e; logic [31:0] rd;
    xact(32'h1000_0004, 1'b1, SIZE_WORD, 1'b0, 32'hDEAD_BEEF, v, e, rd);
    total++; if ({v, e, rd} !== {2'b10, 32'h0}) begin bad++; $display("FAIL sw_rsp got v=%b e=%b rd=%h want v=1 e=0 rd=0", v, e, rd); end
    xact(32'h1000_0004, 1'b0, SIZE_WORD, 1'b0, 32'h0, v, e, rd);
    total++; if ({v, e, rd} !== {2'b10, 32'hDEAD_BEEF}) begin bad++; $display("FAIL lw_rsp got v=%b e=%b rd=%h want v=1 e=0 rd=deadbeef", v, e, rd); end
  endtask

  task automatic test_subword();
    logic v, e; logic [31:0] rd;
    xact(32'h7fff_0000, 1'b1, SIZE_WORD, 1'b0, 32'h1122_3344, v, e, rd);
    xact(32'h7fff_0003, 1'b1, SIZE_BYTE, 1'b0, 32'h0000_0080, v, e, rd);
    total++; if ({v, e} !== 2'b10) begin bad++; $display("FAIL sb_rsp got v=%b e=%b want v=1 e=0", v, e); end
    xact(32'h7fff_0003, 1'b0, SIZE_BYTE, 1'b1, 32'h0, v, e, rd);
    total++; if (rd !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb got %h want ffffff80", rd); end
    xact(32'h7fff_0003, 1'b0, SIZE_BYTE, 1'b0, 32'h0, v, e, rd);
    total++; if (rd !== 32'h0000_0080) begin bad++; $display("FAIL lbu got %h want 00000080", rd); end
    xact(32'h7fff_0000, 1'b0, SIZE_WORD, 1'b0, 32'h0, v, e, rd);
    total++; if (rd !== 32'h8022_3344) begin bad++; $display("FAIL lw_after_sb got %h want 80223344", rd); end
    xact(32'h7fff_0002, 1'b0, SIZE_HALF, 1'b1, 32'h0, v, e, rd);
    total++; if (rd !== 32'hFFFF_8022) begin bad++; $display("FAIL lh got %h want ffff8022", rd); end
    xact(32'h7fff_0000, 1'b0, SIZE_HALF, 1'b0, 32'h0, v, e, rd);
    total++; if (rd !== 32'h0000_3344) begin bad++; $display("FAIL lhu got %h want 00003344", rd); end
  endtask

  task automatic test_faults();
    logic v, e; logic [31:0] rd;
    xact(32'h1000_0001, 1'b0, SIZE_HALF, 1'b1, 32'h0, v, e, rd);
    total++; if ({v, e, rd} !== {2'b11, 32'h0}) begin bad++; $display("FAIL lh_misalign got v=%b e=%b rd=%h want v=1 e=1 rd=0", v, e, rd); end
    xact(32'h1000_0006, 1'b1, SIZE_WORD, 1'b0, 32'h5555_5555, v, e, rd);
    total++; if ({v, e} !== 2'b11) begin bad++; $display("FAIL sw_misalign got v=%b e=%b want v=1 e=1", v, e); end
    xact(32'h1000_0004, 1'b1, 2'b10, 1'b0, 32'h0, v, e, rd);
    total++; if ({v, e} !== 2'b11) begin bad++; $display("FAIL size10 got v=%b e=%b want v=1 e=1", v, e); end
    xact(32'h2000_0000, 1'b0, SIZE_WORD, 1'b0, 32'h0, v, e, rd);
    total++; if ({v, e, rd} !== {2'b11, 32'h0}) begin bad++; $display("FAIL unmapped got v=%b e=%b rd=%h want v=1 e=1 rd=0", v, e, rd); end
    xact(32'h1000_0004, 1'b0, SIZE_WORD, 1'b0, 32'h0, v, e, rd);
    total++; if ({e, rd} !== {1'b0, 32'hDEAD_BEEF}) begin bad++; $display("FAIL fault_no_effect got e=%b rd=%h want e=0 rd=deadbeef", e, rd); end
  endtask

  task automatic test_mmio();
    mmio_start(32'hffff_0008, 1'b0, SIZE_WORD, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      total++; if ({bus.mmio_req_out, bus.mmio_we_out, bus.mmio_be_out, bus.rsp_valid_out} !== {2'b10, 4'hF, 1'b0}) begin bad++; $display("FAIL mmio_wait_ctl c=%0d got %b want 1011110", c, {bus.mmio_req_out, bus.mmio_we_out, bus.mmio_be_out, bus.rsp_valid_out}); end
      total++; if (bus.mmio_addr_out !== 32'hffff_0008) begin bad++; $display("FAIL mmio_addr c=%0d got %h want ffff0008", c, bus.mmio_addr_out); end
      if (c == 2) begin bus.mmio_ack_in = 1'b1; bus.mmio_rdata_in = 32'h0000_005A; end
    end
    @(negedge clock);
    bus.mmio_ack_in = 1'b0;
    total++; if ({bus.rsp_valid_out, bus.rsp_err_out, bus.mmio_req_out} !== 3'b100) begin bad++; $display("FAIL mmio_rsp got v/e/req=%b want 100", {bus.rsp_valid_out, bus.rsp_err_out, bus.mmio_req_out}); end
    total++; if (bus.readdata_out !== 32'h0000_005A) begin bad++; $display("FAIL mmio_rd got %h want 0000005a", bus.readdata_out); end
    mmio_start(32'hffff_0001, 1'b1, SIZE_BYTE, 32'h0000_00A5);
    @(negedge clock);
    total++; if ({bus.mmio_we_out, bus.mmio_be_out, bus.mmio_wdata_out} !== {1'b1, 4'b0010, 32'hA5A5_A5A5}) begin bad++; $display("FAIL mmio_sb got we=%b be=%b wd=%h want 1 0010 a5a5a5a5", bus.mmio_we_out, bus.mmio_be_out, bus.mmio_wdata_out); end
    bus.mmio_ack_in = 1'b1;
    @(negedge clock);
    bus.mmio_ack_in = 1'b0;
    total++; if ({bus.rsp_valid_out, bus.rsp_err_out, bus.readdata_out} !== {2'b10, 32'h0}) begin bad++; $display("FAIL mmio_sb_rsp got v=%b e=%b rd=%h want 1 0 0", bus.rsp_valid_out, bus.rsp_err_out, bus.readdata_out); end
  endtask

  task automatic test_timeout();
    int  hi;
    logic got, e; logic [31:0] rd;
    hi = 0; got = 1'b0; e = 1'b0; rd = 32'h0;
    bus.mmio_rdata_in = 32'h1234_5678;
    mmio_start(32'hffff_0000, 1'b0, SIZE_WORD, 32'h0);
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clock);
      if (bus.mmio_req_out) hi++;
      if (bus.rsp_valid_out) begin got = 1'b1; e = bus.rsp_err_out; rd = bus.readdata_out; end
    end
    total++; if (!got) begin bad++; $display("FAIL timeout_rsp got none want rsp within 10 cycles"); end
    total++; if (hi !== 4) begin bad++; $display("FAIL timeout_req_cycles got %0d want 4", hi); end
    total++; if ({e, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL timeout_err got e=%b rd=%h want e=1 rd=0", e, rd); end
    bus.mmio_rdata_in = 32'h0000_0077;
    mmio_start(32'hffff_0004, 1'b0, SIZE_WORD, 32'h0);
    repeat (4) @(negedge clock);
    total++; if (bus.mmio_req_out !== 1'b1) begin bad++; $display("FAIL coincide_req got %b want 1", bus.mmio_req_out); end
    bus.mmio_ack_in = 1'b1;
    @(negedge clock);
    bus.mmio_ack_in = 1'b0;
    total++; if ({bus.rsp_valid_out, bus.rsp_err_out, bus.readdata_out} !== {2'b10, 32'h77}) begin bad++; $display("FAIL coincide_rsp got v=%b e=%b rd=%h want 1 0 00000077", bus.rsp_valid_out, bus.rsp_err_out, bus.readdata_out); end
  endtask

  task automatic test_reset_mid();
    logic v, e; logic [31:0] rd;
    xact(32'h1000_0008, 1'b1, SIZE_WORD, 1'b0, 32'hCAFE_F00D, v, e, rd);
    mmio_start(32'hffff_000C, 1'b0, SIZE_WORD, 32'h0);
    @(negedge clock);
    total++; if (bus.mmio_req_out !== 1'b1) begin bad++; $display("FAIL pre_reset_req got %b want 1", bus.mmio_req_out); end
    #2 reset = 1'b1;
    #1;
    total++; if ({bus.mmio_req_out, bus.rsp_valid_out, bus.req_ready_out} !== 3'b001) begin bad++; $display("FAIL mid_reset got req/rsp/rdy=%b want 001", {bus.mmio_req_out, bus.rsp_valid_out, bus.req_ready_out}); end
    @(negedge clock); reset = 1'b0;
    bus.mmio_ack_in = 1'b1;
    repeat (2) begin
      @(negedge clock);
      total++; if ({bus.rsp_valid_out, bus.req_ready_out} !== 2'b01) begin bad++; $display("FAIL stray_ack got rsp/rdy=%b want 01", {bus.rsp_valid_out, bus.req_ready_out}); end
    end
    bus.mmio_ack_in = 1'b0;
    xact(32'h1000_0008, 1'b0, SIZE_WORD, 1'b0, 32'h0, v, e, rd);
    total++; if ({v, e, rd} !== {2'b10, 32'hCAFE_F00D}) begin bad++; $display("FAIL post_reset_lw got v=%b e=%b rd=%h want 1 0 cafef00d", v, e, rd); end
  endtask

  initial begin
    bus.req_valid_in = 1'b0; bus.addr_in = '0; bus.we_in = 1'b0; bus.size_in = '0;
    bus.signed_in = 1'b0; bus.writedata_in = '0; bus.mmio_ack_in = 1'b0; bus.mmio_rdata_in = '0;
    test_reset();
    test_word();
    test_subword();
    test_faults();
    test_mmio();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
